// File: rtl/systolic_skew_feeder_if.sv
// Row-in / lane-out bundle between an operand source and the systolic edge feeder.
// master: source/array side; slave: feeder side.
interface systolic_skew_feeder_if #(
   parameter int unsigned N  = 4,
   parameter int unsigned DW = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [N*DW-1:0] in_data;
   logic [N*DW-1:0] lane_data;
   logic [N-1:0]    lane_en;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  lane_data,
      input  lane_en
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output lane_data,
      output lane_en
   );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Systolic array edge feeder: lane i delays row element i by i+1 cycles with matching enables.
// Optional SKEW_FEEDER_STALL_CNT_EN adds stall_cnt (STREAM cycles starved of input).
package params;
   typedef logic [3:0] addrgen_t;
endpackage

module systolic_skew_feeder #(
   parameter int unsigned N  = 4,
   parameter int unsigned DW = 32,
   parameter int unsigned KW = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [KW-1:0]                k_len,
   input  params::addrgen_t             compute_type_in,
   systolic_skew_feeder_if.slave        bus,
   output params::addrgen_t             compute_type_out,
   output logic                         busy,
   output logic                         done
`ifdef SKEW_FEEDER_STALL_CNT_EN
   ,
   output logic [KW-1:0]                stall_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_e;

   localparam int unsigned CW = $clog2(N + 1);

   state_e           state_q, state_d;
   logic [KW-1:0]    klen_q, klen_d;
   logic [KW-1:0]    beats_q, beats_d;
   logic [CW-1:0]    drain_q, drain_d;
   params::addrgen_t ct_q, ct_d;
   logic             zdone_q, zdone_d;
   logic             in_ready;
   logic             accept;
   logic             drain_last;
   logic [N*DW-1:0]  lane_data;
   logic [N-1:0]     lane_en;

   always_comb begin
      state_d    = state_q;
      klen_d     = klen_q;
      beats_d    = beats_q;
      drain_d    = drain_q;
      ct_d       = ct_q;
      zdone_d    = 1'b0;
      in_ready   = 1'b0;
      accept     = 1'b0;
      drain_last = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (k_len != '0) begin
                  state_d = STREAM;
                  klen_d  = k_len;
                  beats_d = '0;
                  ct_d    = compute_type_in;
               end else begin
                  zdone_d = 1'b1;
               end
            end
         end
         STREAM: begin
            in_ready = (beats_q < klen_q);
            accept   = bus.in_valid && in_ready;
            if (accept) begin
               beats_d = beats_q + 1'b1;
               if (beats_d == klen_q) begin
                  state_d = DRAIN;
                  drain_d = '0;
               end
            end
         end
         DRAIN: begin
            // Last beat reaches lane N-1 after N cycles of DRAIN; done follows one cycle later.
            drain_last = (drain_q == CW'(N));
            if (drain_last) state_d = IDLE;
            else            drain_d = drain_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         klen_q  <= '0;
         beats_q <= '0;
         drain_q <= '0;
         ct_q    <= '0;
         zdone_q <= 1'b0;
      end else begin
         state_q <= state_d;
         klen_q  <= klen_d;
         beats_q <= beats_d;
         drain_q <= drain_d;
         ct_q    <= ct_d;
         zdone_q <= zdone_d;
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_lane
      localparam int unsigned D = i + 1;
      logic [DW-1:0] dat_q [D];
      logic          en_q  [D];

      // Data is zeroed on entry when not accepted, so bubbles travel as en=0/data=0.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            for (int unsigned s = 0; s < D; s++) begin
               dat_q[s] <= '0;
               en_q[s]  <= 1'b0;
            end
         end else begin
            en_q[0]  <= accept;
            dat_q[0] <= accept ? bus.in_data[i*DW +: DW] : '0;
            for (int unsigned s = 1; s < D; s++) begin
               en_q[s]  <= en_q[s-1];
               dat_q[s] <= dat_q[s-1];
            end
         end
      end

      assign lane_en[i]             = en_q[D-1];
      assign lane_data[i*DW +: DW]  = en_q[D-1] ? dat_q[D-1] : '0;
   end

   assign bus.in_ready     = in_ready;
   assign bus.lane_data    = lane_data;
   assign bus.lane_en      = lane_en;
   assign compute_type_out = ct_q;
   assign busy             = (state_q != IDLE);
   assign done             = zdone_q | drain_last;

`ifdef SKEW_FEEDER_STALL_CNT_EN
   logic [KW-1:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (state_q == IDLE && start)
         stall_d = '0;
      else if (state_q == STREAM && !bus.in_valid && in_ready && stall_q != '1)
         stall_d = stall_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) stall_q <= '0;
      else        stall_q <= stall_d;
   end

   assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder: directed streams push per-lane/done expectations,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_systolic_skew_feeder;
   localparam int unsigned N  = 4;
   localparam int unsigned DW = 32;
   localparam int unsigned KW = 16;

   typedef struct {
      int            cyc;
      logic [DW-1:0] d;
   } exp_t;

   logic             clk   = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [KW-1:0]    k_len = '0;
   params::addrgen_t ct_in = '0;
   params::addrgen_t ct_out;
   logic             busy;
   logic             done;
`ifdef SKEW_FEEDER_STALL_CNT_EN
   logic [KW-1:0]    stall_cnt;
`endif

   systolic_skew_feeder_if #(.N(N), .DW(DW)) bus_if ();

   systolic_skew_feeder #(.N(N), .DW(DW), .KW(KW)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start            (start),
      .k_len            (k_len),
      .compute_type_in  (ct_in),
      .bus              (bus_if),
      .compute_type_out (ct_out),
      .busy             (busy),
      .done             (done)
`ifdef SKEW_FEEDER_STALL_CNT_EN
      ,
      .stall_cnt        (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   exp_t lq [N][$];
   int   dq [$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   last_beat = 0;
   bit   mon_on = 1'b0;

   function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endfunction

   function automatic logic [DW-1:0] elem(input int b, input int i);
      return DW'(32'hA000_0000 | (b << 8) | i);
   endfunction

   exp_t          m_e;
   logic [DW-1:0] m_ld;
   int            m_dc;

   always @(negedge clk) begin
      if (mon_on) begin
         for (int i = 0; i < N; i++) begin
            m_ld = bus_if.lane_data[i*DW +: DW];
            if (bus_if.lane_en[i] === 1'b1) begin
               if (lq[i].size() == 0) begin
                  chk($sformatf("lane%0d_unexpected_en", i), 1, 0);
               end else begin
                  m_e = lq[i].pop_front();
                  chk($sformatf("lane%0d_cycle", i), cyc, m_e.cyc);
                  chk($sformatf("lane%0d_data", i), m_ld, m_e.d);
               end
            end else begin
               chk($sformatf("lane%0d_en_known", i), bus_if.lane_en[i], 0);
               chk($sformatf("lane%0d_zero_when_disabled", i), m_ld, 0);
            end
         end
         if (done === 1'b1) begin
            if (dq.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               m_dc = dq.pop_front();
               chk("done_cycle", cyc, m_dc);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int k, input params::addrgen_t t);
      start = 1'b1;
      k_len = KW'(k);
      ct_in = t;
      tick();
      start = 1'b0;
   endtask

   task automatic beat(input int b);
      logic [N*DW-1:0] v;
      exp_t            e;
      for (int i = 0; i < N; i++) v[i*DW +: DW] = elem(b, i);
      bus_if.in_valid = 1'b1;
      bus_if.in_data  = v;
      #1;
      chk("in_ready_on_beat", bus_if.in_ready, 1);
      for (int i = 0; i < N; i++) begin
         e.cyc = cyc + 1 + i;
         e.d   = elem(b, i);
         lq[i].push_back(e);
      end
      last_beat = cyc;
      tick();
      bus_if.in_valid = 1'b0;
      bus_if.in_data  = '0;
   endtask

   task automatic finish_stream(input string name);
      dq.push_back(last_beat + N + 1);
      repeat (N + 3) tick();
      chk({name, "_done_seen"}, dq.size(), 0);
      chk({name, "_idle_after"}, busy, 0);
   endtask

   initial begin
      #1_000_000;
      n_fail++;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      bus_if.in_valid = 1'b0;
      bus_if.in_data  = '0;

      // Reset state
      repeat (3) tick();
      mon_on = 1'b1;
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_in_ready", bus_if.in_ready, 0);
      chk("rst_lane_en", bus_if.lane_en, 0);
      chk("rst_lane_data_any", |bus_if.lane_data, 0);
      chk("rst_ct_out", ct_out, 0);
      tick();
      rst_n = 1'b1;
      tick();

      // Basic skew, back-to-back beats
      do_start(3, 4'h5);
      chk("basic_busy", busy, 1);
      chk("basic_ct_out", ct_out, 4'h5);
      beat(0);
      beat(1);
      beat(2);
      finish_stream("basic");

      // Bubble between two beats
      do_start(2, 4'h1);
      beat(10);
      tick();
      beat(11);
      finish_stream("bubble");

      // k_len = 0: done next cycle, never busy
      dq.push_back(cyc + 1);
      do_start(0, 4'h7);
      chk("k0_busy", busy, 0);
      chk("k0_in_ready", bus_if.in_ready, 0);
      repeat (3) tick();
      chk("k0_done_seen", dq.size(), 0);

      // Start while busy and coincident with done is ignored
      do_start(2, 4'h3);
      beat(20);
      start = 1'b1; k_len = KW'(7); ct_in = 4'hC;
      beat(21);
      start = 1'b0;
      chk("ign_ct_during_stream", ct_out, 4'h3);
      dq.push_back(last_beat + N + 1);
      while (cyc < last_beat + N + 1) tick();
      start = 1'b1; k_len = KW'(5); ct_in = 4'hC;
      tick();
      start = 1'b0;
      chk("ign_busy_after_done", busy, 0);
      chk("ign_ct_out_kept", ct_out, 4'h3);
      repeat (2) tick();
      chk("ign_done_seen", dq.size(), 0);

      // Reset mid-stream, then restart
      do_start(8, 4'h2);
      beat(30);
      beat(31);
      beat(32);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < N; i++) lq[i].delete();
      chk("mrst_busy", busy, 0);
      chk("mrst_done", done, 0);
      chk("mrst_in_ready", bus_if.in_ready, 0);
      chk("mrst_lane_en", bus_if.lane_en, 0);
      chk("mrst_lane_data_any", |bus_if.lane_data, 0);
      chk("mrst_ct_out", ct_out, 0);
      repeat (N + 2) tick();
      do_start(3, 4'h6);
      chk("restart_ct_out", ct_out, 4'h6);
      beat(33);
      beat(34);
      beat(35);
      finish_stream("restart");

`ifdef SKEW_FEEDER_STALL_CNT_EN
      // Stall counter: three starved STREAM cycles
      do_start(4, 4'h9);
      beat(40);
      tick();
      tick();
      beat(41);
      tick();
      beat(42);
      beat(43);
      finish_stream("stall");
      chk("stall_cnt_after_done", stall_cnt, 3);
      do_start(1, 4'h9);
      chk("stall_cnt_cleared", stall_cnt, 0);
      beat(44);
      finish_stream("stall2");
`endif

      for (int i = 0; i < N; i++) chk($sformatf("lane%0d_queue_empty", i), lq[i].size(), 0);
      chk("done_queue_empty", dq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
